uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..8).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-003 SHALL have port clk_i  input  1  the single clock.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port baud_en_i  input  1  one-clk-wide bit-rate tick from the baud clock divider.
REQ-006 SHALL have port tx_data_i  input  DATA_BITS  payload byte.
REQ-007 SHALL have port tx_valid_i  input  1  payload valid.
REQ-008 SHALL have port tx_ready_o  output  1  block can accept a payload.
REQ-009 SHALL have port tx_o  output  1  serial line; idle high.
REQ-010 SHALL have port busy_o  output  1  a frame is pending or in progress.

Function
REQ-011 SHALL implement FSM states IDLE, SYNC, START, DATA, PARITY, STOP.
REQ-012 SHALL assert tx_ready_o only in IDLE; transfer occurs when tx_valid_i && tx_ready_o on a clk_i edge.
REQ-013 SHALL latch tx_data_i into a shift register on transfer and move IDLE->SYNC.
REQ-014 SHALL ignore baud_en_i in IDLE, including a tick coincident with transfer.
REQ-015 SHALL, in SYNC, move to START on the next baud_en_i and drive tx_o=0 from the following clock.
REQ-016 SHALL hold every bit from one baud_en_i tick to the next; state and tx_o change only on ticks outside IDLE/SYNC.
REQ-017 SHALL send DATA_BITS bits LSB first, using a bit counter that wraps to 0 on leaving DATA.
REQ-018 SHALL drive tx_o=1 for STOP_BITS bit periods in STOP, then enter IDLE on the tick ending the last stop bit.
REQ-019 SHALL assert busy_o in every state except IDLE.
REQ-020 SHALL leave tx_data_i changes after transfer without effect on the frame in progress.
REQ-021 SHALL never stretch or shorten a bit when baud_en_i is held high continuously; each high clock counts as one tick.

Reset
REQ-022 SHALL, on rst_i high, immediately set state IDLE, tx_o=1, tx_ready_o=1 (combinational from state), busy_o=0, counters 0, shift register 0.
REQ-023 SHALL abort any frame when reset is asserted mid-frame; tx_o returns high without a partial stop.

Configuration
REQ-024 SHALL, with UART_TX_PARITY_EN defined, insert PARITY between DATA and STOP, sending the even parity bit (XOR of the payload bits).
REQ-025 SHALL, without UART_TX_PARITY_EN, omit PARITY so that DATA goes directly to STOP; the PARITY encoding remains reserved.

Structure
REQ-026 SHALL place the FSM state encoding and the IDLE_LEVEL/START_LEVEL/STOP_LEVEL constants in shared package uart_pkg, for reuse by the matching receiver.
REQ-027 SHALL be a single module; no sub-module; the bit tick is supplied externally by clk_divider.

Verification
REQ-028 SHALL check reset: rst_i pulsed mid-DATA of 0xA3 -> tx_o=1, busy_o=0, tx_ready_o=1 in the same cycle; the next frame is correct.
REQ-029 SHALL check basic frame: tick every 4 clocks, send 0x55, parity off -> tx_o bits 0,1,0,1,0,1,0,1,0,1, each 4 clocks long; tx_ready_o returns after 10 bit periods.
REQ-030 SHALL check parity: UART_TX_PARITY_EN set, send 0x55 then 0x07 -> parity bits 0 then 1, 11-bit frames.
REQ-031 SHALL check back-to-back: tx_valid_i held high with 0x01 then 0x80 -> second transfer in the first IDLE cycle, exactly one SYNC gap of at most one bit period between frames.
REQ-032 SHALL check configuration: STOP_BITS=2, DATA_BITS=7, send 0x7F -> start, seven 1s, two stop periods high, busy_o low after 10 periods.
REQ-033 SHALL check tick corners: baud_en_i coincident with transfer is ignored (start begins one tick later); baud_en_i stuck high gives one-clock bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART line levels and FSM state encoding, common to uart_tx and the matching receiver.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Payload handshake, bit tick and line/status signals of one UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_en;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 busy;

  modport master (output baud_en, tx_data, tx_valid, input  tx_ready, tx, busy);
  modport slave  (input  baud_en, tx_data, tx_valid, output tx_ready, tx, busy);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter paced by an external baud tick; define UART_TX_PARITY_EN to append an even parity bit.
import uart_pkg::*;

module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baud_en_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_cnt;
  logic                 stop_cnt;

  always_comb begin
    tx_ready_o = (state == ST_IDLE);
    busy_o     = (state != ST_IDLE);
  end

  // The payload is rotated rather than shifted, so ^shreg stays the payload parity throughout DATA.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      tx_o     <= IDLE_LEVEL;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_valid_i) begin
            shreg <= tx_data_i;
            state <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (baud_en_i) begin
            state <= ST_START;
            tx_o  <= START_LEVEL;
          end
        end
        ST_START: begin
          if (baud_en_i) begin
            state <= ST_DATA;
            tx_o  <= shreg[0];
          end
        end
        ST_DATA: begin
          if (baud_en_i) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= ST_PARITY;
              tx_o    <= ^shreg;
`else
              state   <= ST_STOP;
              tx_o    <= STOP_LEVEL;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {shreg[0], shreg[DATA_BITS-1:1]};
              tx_o    <= shreg[1];
            end
          end
        end
        ST_PARITY: begin
          if (baud_en_i) begin
            state <= ST_STOP;
            tx_o  <= STOP_LEVEL;
          end
        end
        ST_STOP: begin
          if (baud_en_i) begin
            if (stop_cnt == LAST_STOP) begin
              stop_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_o  <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1 instance plus a 7-bit, two-stop-bit instance.
module tb_uart_tx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  uart_tx_if #(.DATA_BITS(8)) bus8 ();
  uart_tx_if #(.DATA_BITS(7)) bus7 ();

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk_i(clk), .rst_i(rst), .baud_en_i(bus8.baud_en), .tx_data_i(bus8.tx_data),
    .tx_valid_i(bus8.tx_valid), .tx_ready_o(bus8.tx_ready), .tx_o(bus8.tx), .busy_o(bus8.busy)
  );

  uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) dut7 (
    .clk_i(clk), .rst_i(rst), .baud_en_i(bus7.baud_en), .tx_data_i(bus7.tx_data),
    .tx_valid_i(bus7.tx_valid), .tx_ready_o(bus7.tx_ready), .tx_o(bus7.tx), .busy_o(bus7.busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input bit tick);
    @(negedge clk);
    bus8.baud_en = tick;
    bus7.baud_en = tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic obs_tx(input int w);
    return (w == 7) ? bus7.tx : bus8.tx;
  endfunction
  function automatic logic obs_busy(input int w);
    return (w == 7) ? bus7.busy : bus8.busy;
  endfunction
  function automatic logic obs_ready(input int w);
    return (w == 7) ? bus7.tx_ready : bus8.tx_ready;
  endfunction

  task automatic set_in(input int w, input logic [7:0] data, input logic valid);
    if (w == 7) begin
      bus7.tx_data  = data[6:0];
      bus7.tx_valid = valid;
    end else begin
      bus8.tx_data  = data;
      bus8.tx_valid = valid;
    end
  endtask

  // One frame: ticks every div clocks; the transfer edge is the first clock of the SYNC
  // period unless xtick puts a (to be ignored) tick on that edge.
  task automatic send(input string tag, input int w, input logic [7:0] data, input int nbits,
                      input int nstop, input logic pbit, input int div, input bit xtick,
                      input bit hold);
    logic exp_bits [16];
    int   nb;
    logic level;
    int   c0;
    exp_bits[0] = START_LEVEL;
    for (int i = 0; i < nbits; i++) exp_bits[1+i] = data[i];
    nb = 1 + nbits;
    if (PAR_ON) begin
      exp_bits[nb] = pbit;
      nb = nb + 1;
    end
    for (int s = 0; s < nstop; s++) begin
      exp_bits[nb] = STOP_LEVEL;
      nb = nb + 1;
    end
    check({tag, " ready-before"}, obs_ready(w), 1'b1);
    set_in(w, data, 1'b1);
    step(xtick);
    check({tag, " xfer-ready"}, obs_ready(w), 1'b0);
    check({tag, " xfer-busy"},  obs_busy(w),  1'b1);
    set_in(w, ~data, hold);
    level = IDLE_LEVEL;
    for (int p = 0; p <= nb; p++) begin
      c0 = (p == 0 && !xtick) ? 2 : 1;
      for (int c = c0; c <= div; c++) begin
        step(c == div);
        if (c == div) level = (p < nb) ? exp_bits[p] : IDLE_LEVEL;
        check($sformatf("%s tx p%0d c%0d", tag, p, c), obs_tx(w), level);
        check($sformatf("%s busy p%0d c%0d", tag, p, c), obs_busy(w),
              (p == nb && c == div) ? 1'b0 : 1'b1);
      end
    end
    check({tag, " ready-after"}, obs_ready(w), 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus8.baud_en = 1'b0; bus8.tx_data = '0; bus8.tx_valid = 1'b0;
    bus7.baud_en = 1'b0; bus7.tx_data = '0; bus7.tx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst tx8",    bus8.tx,       1'b1);
    check("rst ready8", bus8.tx_ready, 1'b1);
    check("rst busy8",  bus8.busy,     1'b0);
    check("rst tx7",    bus7.tx,       1'b1);
    check("rst ready7", bus7.tx_ready, 1'b1);
    check("rst busy7",  bus7.busy,     1'b0);
    @(negedge clk);
    rst = 1'b0;

    send("basic55", 8, 8'h55, 8, 1, 1'b0, 4, 1'b0, 1'b0);
    send("par07",   8, 8'h07, 8, 1, 1'b1, 4, 1'b0, 1'b0);
    send("b2b01",   8, 8'h01, 8, 1, 1'b1, 4, 1'b0, 1'b1);
    send("b2b80",   8, 8'h80, 8, 1, 1'b1, 4, 1'b0, 1'b0);
    send("xtick3c", 8, 8'h3C, 8, 1, 1'b0, 4, 1'b1, 1'b0);
    send("stuck96", 8, 8'h96, 8, 1, 1'b0, 1, 1'b1, 1'b0);
    step(1'b0);

    // Abort 0xA3 while its third data bit (0) is on the line.
    set_in(8, 8'hA3, 1'b1);
    step(1'b0);
    set_in(8, 8'h00, 1'b0);
    for (int k = 2; k <= 16; k++) step(k % 4 == 0);
    step(1'b0);
    check("abort pre-tx",   bus8.tx,   1'b0);
    check("abort pre-busy", bus8.busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort tx",    bus8.tx,       1'b1);
    check("abort busy",  bus8.busy,     1'b0);
    check("abort ready", bus8.tx_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send("afterA3", 8, 8'hA3, 8, 1, 1'b0, 4, 1'b0, 1'b0);

    send("cfg7f", 7, 8'h7F, 7, 2, 1'b1, 4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
